// File: rtl/memswap_pkg.sv
// Constants and state encodings shared by memory_reverser and memory_swapper.
// The swapper's three-step sequence and the reverser's wait window derive from SWAP_WAIT.
package memswap_pkg;

    localparam int unsigned SWAP_WAIT    = 3;
    localparam int unsigned SCRATCH_ADDR = 0;
    localparam int unsigned WAIT_CNT_W   = 2;

    // Counter value one cycle before the final WAIT cycle; the timer flag is registered.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST_PRE = WAIT_CNT_W'(SWAP_WAIT - 2);
    localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_ONE  = WAIT_CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } rev_state_e;

    typedef enum logic [1:0] {
        SW_IDLE    = 2'd0,
        SW_SAVE    = 2'd1,
        SW_COPY    = 2'd2,
        SW_RESTORE = 2'd3
    } swp_state_e;

endpackage

// File: rtl/memory_reverser_if.sv
// Control and swap-request bundle between a requester, memory_reverser and memory_swapper.
interface memory_reverser_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] base;
    logic [N-1:0] limit;
    logic         busy;
    logic         done;
    logic         err;
    logic         swap;
    logic [N-1:0] address_A;
    logic [N-1:0] address_B;

    modport master (
        output start, base, limit,
        input  busy, done, err, swap, address_A, address_B
    );

    modport slave (
        input  start, base, limit,
        output busy, done, err, swap, address_A, address_B
    );
endinterface

// File: rtl/memory_reverser_timer.sv
// Counts the WAIT cycles after each swap request; last marks the final WAIT cycle.
module swap_wait_timer
    import memswap_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic last
);
    logic [WAIT_CNT_W-1:0] cnt_r;
    logic                  last_r;

    // Wait counter with a one-cycle-early compare so last is a clean register output.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r  <= '0;
            last_r <= 1'b0;
        end else if (run) begin
            cnt_r  <= cnt_r + WAIT_CNT_ONE;
            last_r <= (cnt_r == WAIT_LAST_PRE);
        end else begin
            cnt_r  <= '0;
            last_r <= 1'b0;
        end
    end

    assign last = last_r;
endmodule

// File: rtl/memory_swapper.sv
// Exchanges mem[A] and mem[B] in three cycles through the scratch word at SCRATCH_ADDR.
// Write data flows straight from the register file read port selected by rd_addr.
module memory_swapper
    import memswap_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         swap,
    input  logic [N-1:0] address_A,
    input  logic [N-1:0] address_B,
    output logic [N-1:0] rd_addr,
    input  logic [W-1:0] rd_data,
    output logic         we,
    output logic [N-1:0] wr_addr,
    output logic [W-1:0] wr_data
);
    localparam logic [N-1:0] SCRATCH_N = N'(SCRATCH_ADDR);

    swp_state_e   state_r;
    logic [N-1:0] a_r;
    logic [N-1:0] b_r;
    logic [N-1:0] rd_addr_r;
    logic [N-1:0] wr_addr_r;
    logic         we_r;

    // Step sequencer: save A to scratch, copy B to A, restore scratch to B.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= SW_IDLE;
            a_r       <= '0;
            b_r       <= '0;
            rd_addr_r <= '0;
            wr_addr_r <= '0;
            we_r      <= 1'b0;
        end else begin
            case (state_r)
                SW_IDLE: begin
                    if (swap) begin
                        a_r       <= address_A;
                        b_r       <= address_B;
                        rd_addr_r <= address_A;
                        wr_addr_r <= SCRATCH_N;
                        we_r      <= 1'b1;
                        state_r   <= SW_SAVE;
                    end else begin
                        we_r      <= 1'b0;
                    end
                end
                SW_SAVE: begin
                    rd_addr_r <= b_r;
                    wr_addr_r <= a_r;
                    state_r   <= SW_COPY;
                end
                SW_COPY: begin
                    rd_addr_r <= SCRATCH_N;
                    wr_addr_r <= b_r;
                    state_r   <= SW_RESTORE;
                end
                SW_RESTORE: begin
                    we_r    <= 1'b0;
                    state_r <= SW_IDLE;
                end
                default: begin
                    we_r    <= 1'b0;
                    state_r <= SW_IDLE;
                end
            endcase
        end
    end

    assign rd_addr = rd_addr_r;
    assign wr_addr = wr_addr_r;
    assign we      = we_r;
    assign wr_data = rd_data;
endmodule

// File: rtl/reg_file.sv
// 2^N x W storage with one synchronous write port and two asynchronous read ports.
module reg_file #(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         we,
    input  logic [N-1:0] wr_addr,
    input  logic [W-1:0] wr_data,
    input  logic [N-1:0] rd_addr_0,
    output logic [W-1:0] rd_data_0,
    input  logic [N-1:0] rd_addr_1,
    output logic [W-1:0] rd_data_1
);
    logic [W-1:0] mem_r [0:(1<<N)-1];

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wr_addr] <= wr_data;
        end else begin
            mem_r[wr_addr] <= mem_r[wr_addr];
        end
    end

    assign rd_data_0 = mem_r[rd_addr_0];
    assign rd_data_1 = mem_r[rd_addr_1];
endmodule

// File: rtl/memory_reverser.sv
// Reverses the inclusive region [base, limit] by issuing outer-to-inner pair swaps
// to memory_swapper, one pair every 1 + SWAP_WAIT cycles.
module memory_reverser
    import memswap_pkg::*;
#(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    memory_reverser_if.slave bus
);
    localparam logic [N-1:0] SCRATCH_N = N'(SCRATCH_ADDR);
    localparam logic [N-1:0] ONE_N     = N'(1);

    rev_state_e   state_r;
    logic [N-1:0] lo_r;
    logic [N-1:0] hi_r;
    logic [N-1:0] lo_nxt_s;
    logic [N-1:0] hi_nxt_s;
    logic [N-1:0] addr_a_r;
    logic [N-1:0] addr_b_r;
    logic         swap_r;
    logic         busy_r;
    logic         done_r;
    logic         err_r;
    logic         wait_run_s;
    logic         wait_last_s;

    // lo < hi holds whenever these are used, so neither step can wrap.
    assign lo_nxt_s   = lo_r + ONE_N;
    assign hi_nxt_s   = hi_r - ONE_N;
    assign wait_run_s = (state_r == ST_WAIT);

    swap_wait_timer u_wait (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (wait_run_s),
        .last    (wait_last_s)
    );

    // Control FSM; every output is set on the edge that enters the state it belongs to.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            lo_r     <= '0;
            hi_r     <= '0;
            addr_a_r <= '0;
            addr_b_r <= '0;
            swap_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            swap_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        busy_r <= 1'b1;
                        if (bus.base == SCRATCH_N) begin
                            err_r   <= 1'b1;
                            state_r <= ST_ERR;
                        end else if (bus.base >= bus.limit) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            lo_r     <= bus.base;
                            hi_r     <= bus.limit;
                            addr_a_r <= bus.base;
                            addr_b_r <= bus.limit;
                            swap_r   <= 1'b1;
                            state_r  <= ST_ISSUE;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_last_s) begin
                        lo_r <= lo_nxt_s;
                        hi_r <= hi_nxt_s;
                        if (lo_nxt_s < hi_nxt_s) begin
                            addr_a_r <= lo_nxt_s;
                            addr_b_r <= hi_nxt_s;
                            swap_r   <= 1'b1;
                            state_r  <= ST_ISSUE;
                        end else begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DONE, ST_ERR: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.swap      = swap_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.address_A = addr_a_r;
    assign bus.address_B = addr_b_r;
endmodule
